// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with 3-sample majority vote and valid/ready output register.
// Define UART_RX_PARITY_EN for 8E1 framing with a functional parity_err output.
module uart_rx_os #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  // state     | meaning
  // S_IDLE    | line idle, waiting for a low level
  // S_START   | qualifying start bit (false start returns to idle)
  // S_DATA    | sampling 8 data bits, LSB first
  // S_PARITY  | sampling even-parity bit (parity build only)
  // S_STOP    | sampling stop bit, delivering or flagging the frame
  // S_WAIT_HIGH | after a framing error, wait for the line to return high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int DW      = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic [DW-1:0] r_div;
  logic [3:0]    r_sc;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_s7, r_s8;
  logic [7:0]    r_data;
  logic          r_valid, r_ferr, r_oerr;

  logic w_rxs, w_tick, w_vote, w_mid, w_end;
  logic w_start, w_shift_en, w_deliver, w_frame;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_div == '0);
  assign w_mid  = w_tick && (r_sc == 4'd9);
  assign w_end  = w_tick && (r_sc == 4'd15);
  assign w_vote = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_perr, w_par_capture, w_par_fail;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    w_frame     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_capture = 1'b0;
    w_par_fail    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_start     = 1'b1;
        end
      end
      S_START: begin
        if (w_mid && w_vote) w_state_nxt = S_IDLE;
        else if (w_end)      w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_shift_en = w_mid;
        if (w_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        w_par_capture = w_mid;
        if (w_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // Leave right after the vote so the next start edge is caught early
        if (w_mid) begin
          if (!w_vote) begin
            w_frame     = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if (r_par_bad) begin
            w_par_fail  = 1'b1;
            w_state_nxt = S_IDLE;
          end
`endif
          else begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_div     <= DIV_LAST;
      r_sc      <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx_line};
      // Tick phase re-aligns to every start edge
      if (w_start) begin
        r_div     <= DIV_LAST;
        r_sc      <= 4'd0;
        r_bit_idx <= 3'd0;
      end else begin
        r_div <= w_tick ? DIV_LAST : r_div - 1'b1;
        if (w_tick) r_sc <= r_sc + 4'd1;
        if ((r_state == S_DATA) && w_end) r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_tick && (r_sc == 4'd7)) r_s7 <= w_rxs;
      if (w_tick && (r_sc == 4'd8)) r_s8 <= w_rxs;
      if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};
      r_ferr <= w_frame;
      r_oerr <= 1'b0;
      if (w_deliver) begin
        if (r_valid && !rx_ready) begin
          r_oerr <= 1'b1;
        end else begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (w_par_capture) r_par_bad <= w_vote ^ (^r_shift);
      r_perr <= w_par_fail;
    end
  end
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampling UART receiver with majority-vote bit sampling, framing/overrun detection and a valid/ready output register. Sits between the asynchronous serial input pin and the byte-oriented consumer logic, as the receive-side counterpart to the existing UART transmit path in `uart_top`. Frame format is 8N1, with optional even parity.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s. Oversample tick divider is `CLK_FREQ/(BAUD*16)`, integer-truncated and ≥ 2. The default is 27.
- `clk`  in  1  system clock; everything is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_line`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_data`  out  8  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accept; transfer when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: byte completed while output register still full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration).

## Operation
- **Synchronizer.** `rx_line` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rxs`.
- **Tick generator.** A divider emits a 1-clk `tick` every `CLK_FREQ/(BAUD*16)` clocks. The divider and a 4-bit sample counter `sc` are cleared on IDLE→START.
- **FSM:** IDLE, START, DATA, PARITY (only with macro), STOP, WAIT_HIGH.
- **IDLE.** On `rxs`=0, go to START.
- **START.** The vote is the majority of samples at `sc`=7,8,9.
  - Vote 1: false start; return to IDLE with no outputs.
  - Vote 0: go to DATA at `sc`=15, with `bit_idx`=0.
- **DATA.** The same majority vote at `sc`=7,8,9 of each bit period. Bits shift into the shift register LSB-first. After `bit_idx`=7 completes, go to PARITY or STOP.
- **PARITY.** Vote on the parity bit; compare against even parity of the 8 data bits.
- **STOP.** Vote on the stop bit at `sc`=9.
  - Vote 1, no parity error: deliver the byte (see output register).
  - Vote 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - Parity error: pulse `parity_err`, discard the byte.
  - No error: go to IDLE right after the vote, so a following start bit can be detected within half a bit period.
- **WAIT_HIGH.** Stay until `rxs`=1 (this handles break conditions), then go to IDLE.
- **Output register.**
  - Delivery into an empty register: `rx_data` is loaded and `rx_valid` is set.
  - Delivery while `rx_valid`=1 and `rx_ready`=0 in the same cycle: the new byte is dropped, `rx_data` is unchanged, and `overrun_err` pulses.
  - Delivery while `rx_valid & rx_ready` in the same cycle: accept the old byte and load the new one. `rx_valid` stays 1 and there is no overrun.
  - `rx_valid` clears the cycle after a transfer with no new delivery.
- **Error priority.** If both stop and parity are bad, only `frame_err` pulses. Error pulses are independent of `rx_valid`.

## Timing
- **Reset values.** Everything below is forced while `reset_n`=0:
  - `rx_data`=8'h00; `rx_valid`, `frame_err`, `overrun_err`, `parity_err` = 0.
  - FSM = IDLE; synchronizer = 1.
- **Mid-frame reset.** The partial frame is discarded. After release the block is in IDLE. A low line at that point is treated as a start bit.
- **Latency.** `rx_valid` rises 1 clk after the stop-bit vote tick. Measured from the `rx_line` falling edge, this is about 2 sync clks plus (16·9 + 10) ticks, or (16·10 + 10) ticks with parity.
- **Vote tolerance.** One-tick glitches inside a bit are rejected by the vote. A low pulse shorter than about 7 ticks at the start is a false start.
- **Jitter.** The tick phase re-aligns on every start edge. Accumulated error within a frame must stay below ±6 ticks; at the default divider the error is under 0.5%.
- **Handshake.** `rx_ready` may be held high permanently. `rx_data` is stable while `rx_valid`=1.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the frame is 8E1. The PARITY state is present and `parity_err` is functional.
- **Not defined:** the frame is 8N1. There is no PARITY state and `parity_err` is tied 0. The port always exists.

## Test plan
- **Nominal byte.** After `reset_n` is released, drive an 8N1 frame carrying 0x54 at BAUD with `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=0x54; all error outputs stay 0.
- **False start.** Drive a 4-tick low glitch on an idle line, then frame 0xA5 → only 0xA5 is delivered; no errors.
- **Bad stop bit.** Send frame 0x3C with the stop bit forced low for 2 bit periods, then frame 0x81 → one `frame_err` pulse, no `rx_valid` for 0x3C, then 0x81 received correctly.
- **Overrun.** Hold `rx_ready`=0 and send 0x11 then 0x22 back-to-back → `rx_data` stays 0x11 and `overrun_err` pulses once. Raising `rx_ready` clears `rx_valid` the next cycle.
- **Reset mid-frame.** Assert `reset_n`=0 during bit 4 of frame 0xFF → outputs return to reset values immediately. After release, frame 0x0F is received correctly.
- **Parity (`UART_RX_PARITY_EN`).** Send frame 0x07 with the parity bit set to 1 → no `parity_err`, byte delivered. With the parity bit set to 0 → `parity_err` pulse, no `rx_valid`.
